// File: rtl/r88_pkg.sv
// r88_pkg: definitions shared by the R88 general-register file.
//   - Register address width and pair-index width.
//   - Encodings for the pair increment/decrement sequencer states.
package r88_pkg;

   localparam int REG_AW  = 3;   // eight registers R0..R7
   localparam int PAIR_W  = 2;   // four 16-bit pairs
   localparam int BYTE_W  = 8;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LOW  = 2'd1,
      SEQ_HIGH = 2'd2
   } seqState_t;

endpackage

// File: rtl/r88_incdec8.sv
// r88_incdec8: combinational 8-bit increment/decrement by one.
// Ports:
//   byteIn   in  8  operand
//   dec      in  1  0 = +1, 1 = -1
//   byteOut  out 8  result (wraps)
//   carry    out 1  carry out of +1 (operand was 0xFF) or borrow out of -1 (operand was 0x00)
module r88_incdec8
   import r88_pkg::*;
(
   input  logic [BYTE_W-1:0] byteIn,
   input  logic              dec,
   output logic [BYTE_W-1:0] byteOut,
   output logic              carry
);

   always_comb begin
      if (dec) begin
         byteOut = byteIn - 8'd1;
         carry   = (byteIn == 8'h00);
      end else begin
         byteOut = byteIn + 8'd1;
         carry   = (byteIn == 8'hFF);
      end
   end

endmodule

// File: rtl/r88_regfile.sv
// r88_regfile: eight 8-bit general registers feeding the ALU operands.
// Ports:
//   sysClock, sysReset        clock; asynchronous active-high reset
//   intD                      shared internal data bus (load source / drive target)
//   leftAddr, rightAddr       select registers shown on regLeft / regRight
//   wrEn, wrAddr              load intD into R[wrAddr] at the next edge
//   busOutEn, busAddr         drive R[busAddr] onto intD
//   pairStart, pairDec, pairSel  start a 16-bit +/-1 on pair R[2n]:R[2n+1]
//   busy, pairDone, pairZero  sequencer status; pairZero valid with pairDone
module r88_regfile
   import r88_pkg::*;
#(
   parameter int NUM_REGS = 8
)
(
   input  logic              sysClock,
   input  logic              sysReset,
   inout  wire  [BYTE_W-1:0] intD,
   input  logic [REG_AW-1:0] leftAddr,
   input  logic [REG_AW-1:0] rightAddr,
   output logic [BYTE_W-1:0] regLeft,
   output logic [BYTE_W-1:0] regRight,
   input  logic              wrEn,
   input  logic [REG_AW-1:0] wrAddr,
   input  logic              busOutEn,
   input  logic [REG_AW-1:0] busAddr,
   input  logic              pairStart,
   input  logic              pairDec,
   input  logic [PAIR_W-1:0] pairSel,
   output logic              busy,
   output logic              pairDone,
   output logic              pairZero
);

   logic [BYTE_W-1:0] regs [NUM_REGS];

   seqState_t         seqState, seqNext;
   logic              pairDecQ;
   logic [PAIR_W-1:0] pairSelQ;
   logic              latchReq;
   logic              seqWr;
   logic              doneNext, zeroNext;
   logic [REG_AW-1:0] hiAddr, loAddr, seqAddr;
   logic [BYTE_W-1:0] incIn, incOut;
   logic              incCarry;

   // Reads come straight from the flops: a write is visible only after its edge.
   assign regLeft  = regs[leftAddr];
   assign regRight = regs[rightAddr];
   assign intD     = busOutEn ? regs[busAddr] : 'z;
   assign busy     = (seqState != SEQ_IDLE);

   assign hiAddr  = {pairSelQ, 1'b0};
   assign loAddr  = {pairSelQ, 1'b1};
   assign seqAddr = (seqState == SEQ_HIGH) ? hiAddr : loAddr;
   assign incIn   = regs[seqAddr];

   r88_incdec8 uIncDec (
      .byteIn  (incIn),
      .dec     (pairDecQ),
      .byteOut (incOut),
      .carry   (incCarry)
   );

   always_comb begin
      seqNext  = seqState;
      seqWr    = 1'b0;
      latchReq = 1'b0;
      doneNext = 1'b0;
      zeroNext = 1'b0;
      case (seqState)
         SEQ_IDLE: begin
            if (pairStart) begin
               seqNext  = SEQ_LOW;
               latchReq = 1'b1;
            end
         end
         SEQ_LOW: begin
            seqWr = 1'b1;
            if (incCarry) begin
               seqNext = SEQ_HIGH;
            end else begin
               // High byte untouched, so its current value is final.
               seqNext  = SEQ_IDLE;
               doneNext = 1'b1;
               zeroNext = (regs[hiAddr] == 8'h00) && (incOut == 8'h00);
            end
         end
         SEQ_HIGH: begin
            // Low byte was already written in the LOW step.
            seqWr    = 1'b1;
            seqNext  = SEQ_IDLE;
            doneNext = 1'b1;
            zeroNext = (incOut == 8'h00) && (regs[loAddr] == 8'h00);
         end
         default: seqNext = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge sysClock or posedge sysReset) begin
      if (sysReset) begin
         seqState <= SEQ_IDLE;
         pairDecQ <= 1'b0;
         pairSelQ <= '0;
         pairDone <= 1'b0;
         pairZero <= 1'b0;
      end else begin
         seqState <= seqNext;
         pairDone <= doneNext;
         pairZero <= zeroNext;
         if (latchReq) begin
            pairDecQ <= pairDec;
            pairSelQ <= pairSel;
         end
      end
   end

   // The sequencer owns the byte it is updating; a bus load to that same
   // byte in the same cycle is discarded.
   always_ff @(posedge sysClock or posedge sysReset) begin
      if (sysReset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (wrEn && !(seqWr && (wrAddr == seqAddr)))
            regs[wrAddr] <= intD;
         if (seqWr)
            regs[seqAddr] <= incOut;
      end
   end

endmodule

// File: tb/tb_r88_regfile.sv
module tb_r88_regfile;

   logic       sysClock = 1'b0;
   logic       sysReset = 1'b0;
   wire  [7:0] intD;
   logic [2:0] leftAddr = '0, rightAddr = '0, wrAddr = '0, busAddr = '0;
   logic [7:0] regLeft, regRight;
   logic       wrEn = 1'b0, busOutEn = 1'b0;
   logic       pairStart = 1'b0, pairDec = 1'b0;
   logic [1:0] pairSel = '0;
   logic       busy, pairDone, pairZero;

   logic       tbDrvEn = 1'b0;
   logic [7:0] tbDrv = '0;
   assign intD = tbDrvEn ? tbDrv : 'z;

   int total = 0;
   int bad   = 0;
   bit chkOn = 1'b0;

   r88_regfile #(.NUM_REGS(8)) dut (
      .sysClock (sysClock),
      .sysReset (sysReset),
      .intD     (intD),
      .leftAddr (leftAddr),
      .rightAddr(rightAddr),
      .regLeft  (regLeft),
      .regRight (regRight),
      .wrEn     (wrEn),
      .wrAddr   (wrAddr),
      .busOutEn (busOutEn),
      .busAddr  (busAddr),
      .pairStart(pairStart),
      .pairDec  (pairDec),
      .pairSel  (pairSel),
      .busy     (busy),
      .pairDone (pairDone),
      .pairZero (pairZero)
   );

   always #5 sysClock = ~sysClock;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: registers as a plain array, pair op as 16-bit arithmetic.
   // mPhase counts which byte lands at the coming edge (1 = low, 2 = high).
   logic [7:0]  m [8];
   int          mPhase = 0;
   bit          mDec;
   int          mSel;
   logic [7:0]  mPendHigh;
   bit          mDone = 1'b0, mZero = 1'b0;

   always @(posedge sysClock or posedge sysReset) begin
      if (sysReset) begin
         for (int i = 0; i < 8; i++) m[i] = 8'h00;
         mPhase = 0; mDone = 1'b0; mZero = 1'b0;
      end else begin
         logic [7:0]  wdata;
         logic [15:0] v, r;
         int          blockAddr;
         wdata     = busOutEn ? m[busAddr] : tbDrv;
         blockAddr = -1;
         mDone     = 1'b0;
         mZero     = 1'b0;
         if (mPhase == 1) begin
            blockAddr = 2*mSel + 1;
            v = {m[2*mSel], m[2*mSel+1]};
            r = mDec ? v - 16'd1 : v + 16'd1;
            m[2*mSel+1] = r[7:0];
            if (r[15:8] != v[15:8]) begin
               mPendHigh = r[15:8];
               mPhase = 2;
            end else begin
               mPhase = 0; mDone = 1'b1; mZero = (r == 16'h0000);
            end
         end else if (mPhase == 2) begin
            blockAddr = 2*mSel;
            m[2*mSel] = mPendHigh;
            mPhase = 0; mDone = 1'b1;
            mZero = ({mPendHigh, m[2*mSel+1]} == 16'h0000);
         end else if (pairStart) begin
            mPhase = 1; mDec = pairDec; mSel = int'(pairSel);
         end
         if (wrEn && (int'(wrAddr) != blockAddr)) m[wrAddr] = wdata;
      end
   end

   // Compare process: every falling edge once out of the initial reset.
   always @(negedge sysClock) begin
      if (chkOn) begin
         check("regLeft",  regLeft,  m[leftAddr]);
         check("regRight", regRight, m[rightAddr]);
         check("busy",     busy,     (mPhase != 0));
         check("pairDone", pairDone, mDone);
         if (mDone) check("pairZero", pairZero, mZero);
         if (busOutEn && !tbDrvEn) check("intD", intD, m[busAddr]);
      end
   end

   task automatic cyc();
      @(posedge sysClock);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      tbDrvEn = 1'b1; tbDrv = d; wrEn = 1'b1; wrAddr = a;
      cyc();
      tbDrvEn = 1'b0; wrEn = 1'b0;
   endtask

   // Called in the cycle right after the accepting edge; returns the cycle
   // index (start cycle = 0) in which pairDone is seen.
   task automatic waitDone(output int n);
      n = 1;
      while (!pairDone && n < 12) begin
         cyc();
         n++;
      end
      if (!pairDone) check("pairDoneTimeout", 0, 1);
   endtask

   initial begin
      int n;

      // Reset state
      #1 sysReset = 1'b1;
      #1;
      check("rstBusy", busy, 0);
      check("rstDone", pairDone, 0);
      check("rstZero", pairZero, 0);
      check("rstR0", regLeft, 8'h00);
      cyc(); cyc();
      sysReset = 1'b0;
      chkOn = 1'b1;

      // Write R3 and read it on both ports
      leftAddr = 3; rightAddr = 3;
      wr(3, 8'h5A);
      check("wrLeft", regLeft, 8'h5A);
      check("wrRight", regRight, 8'h5A);
      rightAddr = 0;
      #1 check("readR0", regRight, 8'h00);

      // Bus drive and register-to-register copy
      busOutEn = 1'b1; busAddr = 3;
      #1 check("busDrive", intD, 8'h5A);
      wrEn = 1'b1; wrAddr = 6;
      cyc();
      wrEn = 1'b0; busOutEn = 1'b0;
      leftAddr = 6;
      #1 check("busCopy", regLeft, 8'h5A);

      // 0x12FF + 1 on pair 1: carry into high byte
      wr(2, 8'h12); wr(3, 8'hFF);
      leftAddr = 2; rightAddr = 3;
      pairStart = 1'b1; pairDec = 1'b0; pairSel = 2'd1;
      cyc();
      pairStart = 1'b0;
      waitDone(n);
      check("latCarry", n, 3);
      check("p1High", regLeft, 8'h13);
      check("p1Low", regRight, 8'h00);
      check("p1Zero", pairZero, 0);

      // 0x0001 - 1 on pair 0: no borrow, then back-to-back +1
      wr(1, 8'h01);
      leftAddr = 0; rightAddr = 1;
      pairStart = 1'b1; pairDec = 1'b1; pairSel = 2'd0;
      cyc();
      pairStart = 1'b0;
      waitDone(n);
      check("latNoCarry", n, 2);
      check("p0Zero", pairZero, 1);
      check("p0Low", regRight, 8'h00);
      pairStart = 1'b1; pairDec = 1'b0;
      cyc();
      pairStart = 1'b0;
      check("b2bBusy", busy, 1);
      waitDone(n);
      check("latB2b", n, 2);
      check("b2bLow", regRight, 8'h01);
      check("b2bZero", pairZero, 0);

      // 0xFFFF + 1 on pair 3 with write conflicts and an ignored start
      wr(6, 8'hFF); wr(7, 8'hFF);
      leftAddr = 6; rightAddr = 7;
      pairStart = 1'b1; pairDec = 1'b0; pairSel = 2'd3;
      cyc();
      // LOW cycle: R7 load dropped, second start ignored
      pairStart = 1'b1; pairSel = 2'd0; pairDec = 1'b1;
      tbDrvEn = 1'b1; tbDrv = 8'hAA; wrEn = 1'b1; wrAddr = 7;
      cyc();
      pairStart = 1'b0;
      // HIGH cycle: R4 load lands while busy
      tbDrv = 8'h3C; wrAddr = 4;
      cyc();
      tbDrvEn = 1'b0; wrEn = 1'b0;
      n = 3;
      if (!pairDone) waitDone(n);
      check("latWrap", n, 3);
      check("wrapZero", pairZero, 1);
      check("wrapHigh", regLeft, 8'h00);
      check("wrapLow", regRight, 8'h00);
      cyc();
      check("ignoredStart", busy, 0);
      leftAddr = 4;
      #1 check("r4Landed", regLeft, 8'h3C);

      // Reset during the HIGH step
      wr(3, 8'hFF);
      leftAddr = 2; rightAddr = 3;
      pairStart = 1'b1; pairDec = 1'b0; pairSel = 2'd1;
      cyc();
      pairStart = 1'b0;
      cyc();
      check("inHigh", busy, 1);
      check("inHighLow", regRight, 8'h00);
      sysReset = 1'b1;
      #1;
      check("midRstBusy", busy, 0);
      check("midRstHigh", regLeft, 8'h00);
      check("midRstDone", pairDone, 0);
      cyc();
      sysReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("noDoneAfterRst", pairDone, 0);
      end
      leftAddr = 4;
      #1 check("rstR4", regLeft, 8'h00);

      chkOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
